// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Constants and types shared by the register-file blocks: the operand-read
// arbiter, the writeback path and the hold scoreboard.
//   NUM_REGS     : number of architectural registers (hold vector width)
//   IDX_W        : register index width
//   STALL_CNT_W  : width of the consecutive-stall counter
//   hold_state_e : scoreboard sequencing states RUN / STALL / DRAIN
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int NUM_REGS    = 16;
  localparam int IDX_W       = 4;
  localparam int STALL_CNT_W = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } hold_state_e;

endpackage : regfile_pkg

// File: rtl/reg_hold_lookup.sv
// ---------------------------------------------------------------------------
// reg_hold_lookup
// Selects one bit of a register-indexed vector (WIDTH:1 mux).
//   vec_i : vector indexed by register number
//   idx_i : register index
//   bit_o : vec_i[idx_i]; 0 if idx_i is beyond WIDTH-1
// ---------------------------------------------------------------------------
module reg_hold_lookup #(
  parameter int WIDTH = regfile_pkg::NUM_REGS,
  parameter int SEL_W = regfile_pkg::IDX_W
) (
  input  logic [WIDTH-1:0] vec_i,
  input  logic [SEL_W-1:0] idx_i,
  output logic             bit_o
);

  // AND-OR form: decode the index, mask the vector, reduce.
  logic [WIDTH-1:0] sel;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sel
    assign sel[gi] = vec_i[gi] && (idx_i == SEL_W'(gi));
  end

  assign bit_o = |sel;

endmodule : reg_hold_lookup

// File: rtl/reg_hold_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_hold_scoreboard
// Tracks outstanding register writes and gates instruction issue.
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   issue_valid      : instruction presented for issue
//   issue_ready      : combinational accept for this cycle
//   issue_opnd1/2    : source indices, qualified by issue_is_opnd1/2
//   issue_dest       : destination index, qualified by issue_is_dest
//   wb_valid/wb_dest : per-port writeback strobe and index
//   flush            : single-cycle drain request
//   hold_Q           : registered hold vector (bit n = write pending to rn)
//   busy             : registered, sequencer not in RUN
//   stall_cycles     : saturating consecutive-stall count
//   watchdog_err     : sticky, stall count reached STALL_LIMIT
//   spurious_wb      : registered pulse, writeback hit a clear hold bit
// ---------------------------------------------------------------------------
module reg_hold_scoreboard #(
  parameter int NUM_REGS    = regfile_pkg::NUM_REGS,
  parameter int IDX_W       = regfile_pkg::IDX_W,
  parameter int NUM_WB      = 2,
  parameter int STALL_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [IDX_W-1:0]        issue_opnd1,
  input  logic                    issue_is_opnd1,
  input  logic [IDX_W-1:0]        issue_opnd2,
  input  logic                    issue_is_opnd2,
  input  logic [IDX_W-1:0]        issue_dest,
  input  logic                    issue_is_dest,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_dest,
  input  logic                    flush,
  output logic [NUM_REGS-1:0]     hold_Q,
  output logic                    busy,
  output logic [7:0]              stall_cycles,
  output logic                    watchdog_err,
  output logic                    spurious_wb
);

  import regfile_pkg::*;

  localparam logic [7:0] STALL_LIMIT_C = 8'(STALL_LIMIT);

  hold_state_e         state_q;
  logic [NUM_REGS-1:0] hold_q, hold_d;
  logic [7:0]          stall_cnt_q, stall_cnt_d;
  logic                watchdog_q;
  logic                spurious_q;
  logic                busy_q;

  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] eff_hold;
  logic [NUM_REGS-1:0] set;
  logic [NUM_WB-1:0]   spur_hit;
  logic                opnd1_held, opnd2_held, dest_held;
  logic                haz;
  logic                can_issue;
  logic                fire;

  // -------------------------------------------------------------------------
  // Writeback clear mask: a register is cleared if any port targets it.
  // Two ports naming the same register simply OR into one clear.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_clr
    logic [NUM_WB-1:0] hit;
    for (genvar gk = 0; gk < NUM_WB; gk++) begin : g_port
      assign hit[gk] = wb_valid[gk] && (wb_dest[gk*IDX_W +: IDX_W] == IDX_W'(gi));
    end
    assign clr[gi] = |hit;
  end

  // Spurious check looks at the registered hold vector, before this cycle's
  // clears, so a duplicated writeback on a held register is not flagged.
  for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_spur
    assign spur_hit[gi] = wb_valid[gi] && !hold_q[wb_dest[gi*IDX_W +: IDX_W]];
  end

  // Same-cycle writeback bypasses the hazard.
  assign eff_hold = hold_q & ~clr;

  reg_hold_lookup #(.WIDTH(NUM_REGS), .SEL_W(IDX_W)) u_lk_opnd1 (
    .vec_i (eff_hold),
    .idx_i (issue_opnd1),
    .bit_o (opnd1_held)
  );

  reg_hold_lookup #(.WIDTH(NUM_REGS), .SEL_W(IDX_W)) u_lk_opnd2 (
    .vec_i (eff_hold),
    .idx_i (issue_opnd2),
    .bit_o (opnd2_held)
  );

  reg_hold_lookup #(.WIDTH(NUM_REGS), .SEL_W(IDX_W)) u_lk_dest (
    .vec_i (eff_hold),
    .idx_i (issue_dest),
    .bit_o (dest_held)
  );

  // Dest term is the WAW check; unqualified index fields never contribute.
  assign haz = (issue_is_opnd1 && opnd1_held) ||
               (issue_is_opnd2 && opnd2_held) ||
               (issue_is_dest  && dest_held);

  assign can_issue   = (state_q == RUN) || (state_q == STALL);
  // A flush cycle never accepts an instruction.
  assign issue_ready = can_issue && !haz && !flush;
  assign fire        = issue_valid && issue_ready;

  // Set is ORed after the clear so a reissue of a just-written register wins.
  assign set    = (fire && issue_is_dest) ?
                  ({{(NUM_REGS-1){1'b0}}, 1'b1} << issue_dest) : '0;
  assign hold_d = eff_hold | set;

  // Counter advances only while the sequencer remains in STALL; every
  // other path (fire, withdraw, flush, not stalling) returns it to zero.
  always_comb begin
    stall_cnt_d = '0;
    if ((state_q == STALL) && !flush && issue_valid && !fire) begin
      stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer and registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      busy_q      <= 1'b0;
      hold_q      <= '0;
      stall_cnt_q <= '0;
      watchdog_q  <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
      spurious_q  <= |spur_hit;

      if ((stall_cnt_d != 8'd0) && (stall_cnt_d == STALL_LIMIT_C)) begin
        watchdog_q <= 1'b1;
      end

      if (flush && (state_q != DRAIN)) begin
        state_q <= DRAIN;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (issue_valid && haz) begin
              state_q <= STALL;
              busy_q  <= 1'b1;
            end
          end
          STALL: begin
            if (fire || !issue_valid) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
            end
          end
          DRAIN: begin
            // Leave as soon as the vector being loaded is empty.
            if (hold_d == '0) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hold_Q       = hold_q;
  assign busy         = busy_q;
  assign stall_cycles = stall_cnt_q;
  assign watchdog_err = watchdog_q;
  assign spurious_wb  = spurious_q;

endmodule : reg_hold_scoreboard

// File: tb/tb_reg_hold_scoreboard.sv
module tb_reg_hold_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  issue_opnd1 = '0;
  logic        issue_is_opnd1 = 1'b0;
  logic [3:0]  issue_opnd2 = '0;
  logic        issue_is_opnd2 = 1'b0;
  logic [3:0]  issue_dest = '0;
  logic        issue_is_dest = 1'b0;
  logic [1:0]  wb_valid = '0;
  logic [7:0]  wb_dest = '0;
  logic        flush = 1'b0;
  logic [15:0] hold_Q;
  logic        busy;
  logic [7:0]  stall_cycles;
  logic        watchdog_err;
  logic        spurious_wb;

  always #5 clk = ~clk;

  reg_hold_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_opnd1    (issue_opnd1),
    .issue_is_opnd1 (issue_is_opnd1),
    .issue_opnd2    (issue_opnd2),
    .issue_is_opnd2 (issue_is_opnd2),
    .issue_dest     (issue_dest),
    .issue_is_dest  (issue_is_dest),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .flush          (flush),
    .hold_Q         (hold_Q),
    .busy           (busy),
    .stall_cycles   (stall_cycles),
    .watchdog_err   (watchdog_err),
    .spurious_wb    (spurious_wb)
  );

  typedef struct {
    bit       valid;
    bit [3:0] o1;
    bit       is1;
    bit [3:0] o2;
    bit       is2;
    bit [3:0] d;
    bit       isd;
    bit [1:0] wbv;
    bit [7:0] wbd;
    bit       fl;
  } stim_t;

  typedef struct {
    stim_t     s;
    bit        rdy;
    bit [15:0] hold;
    bit        busy;
    bit [7:0]  cnt;
    bit        spur;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a set of pending registers plus a mode name.
  localparam int M_RUN = 0, M_STALL = 1, M_DRAIN = 2;
  localparam int LIMIT = 255;
  bit [15:0] m_hold;
  int        m_mode;
  int        m_cnt;
  bit        m_wd;
  bit        m_spur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hold = '0; m_mode = M_RUN; m_cnt = 0; m_wd = 0; m_spur = 0;
  endfunction

  // A source/dest is blocked if its register is pending and not being
  // written back right now.
  function automatic bit model_ready(input stim_t s);
    bit [15:0] pend = m_hold;
    for (int k = 0; k < 2; k++)
      if (s.wbv[k]) pend[s.wbd[k*4 +: 4]] = 1'b0;
    if (m_mode == M_DRAIN || s.fl) return 1'b0;
    if (s.is1 && pend[s.o1]) return 1'b0;
    if (s.is2 && pend[s.o2]) return 1'b0;
    if (s.isd && pend[s.d])  return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input stim_t s, input bit rdy);
    bit [15:0] nh = m_hold;
    bit spur = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (s.wbv[k]) begin
        if (!m_hold[s.wbd[k*4 +: 4]]) spur = 1'b1;
        nh[s.wbd[k*4 +: 4]] = 1'b0;
      end
    end
    if (s.valid && rdy && s.isd) nh[s.d] = 1'b1;
    if (s.fl && m_mode != M_DRAIN) begin
      m_mode = M_DRAIN; m_cnt = 0;
    end else if (m_mode == M_RUN) begin
      if (s.valid && !rdy) m_mode = M_STALL;
    end else if (m_mode == M_STALL) begin
      if (s.valid && !rdy) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else begin m_mode = M_RUN; m_cnt = 0; end
    end else begin
      if (nh == 16'h0) m_mode = M_RUN;
    end
    if (m_cnt == LIMIT) m_wd = 1'b1;
    m_hold = nh;
    m_spur = spur;
  endfunction

  task automatic drive(input stim_t s);
    issue_valid = s.valid; issue_opnd1 = s.o1; issue_is_opnd1 = s.is1;
    issue_opnd2 = s.o2; issue_is_opnd2 = s.is2;
    issue_dest = s.d; issue_is_dest = s.isd;
    wb_valid = s.wbv; wb_dest = s.wbd; flush = s.fl;
  endtask

  // One clock of stimulus: ready checked mid-cycle, registers checked
  // just after the rising edge, both against the model.
  task automatic run_cycle(input stim_t s, input string tag, output bit got_rdy);
    bit rdy;
    @(negedge clk);
    drive(s);
    #1;
    rdy = model_ready(s);
    got_rdy = issue_ready;
    chk({tag, " issue_ready"}, issue_ready, rdy);
    @(posedge clk);
    model_step(s, rdy);
    #1;
    chk({tag, " hold_Q"}, hold_Q, m_hold);
    chk({tag, " busy"}, busy, (m_mode != M_RUN));
    chk({tag, " stall_cycles"}, stall_cycles, m_cnt);
    chk({tag, " watchdog_err"}, watchdog_err, m_wd);
    chk({tag, " spurious_wb"}, spurious_wb, m_spur);
    $display("%s v=%0b fl=%0b wb=%0b/%02h rdy=%0b hold=%04h busy=%0b cnt=%0d wd=%0b sp=%0b",
             tag, s.valid, s.fl, s.wbv, s.wbd, got_rdy, hold_Q, busy, stall_cycles,
             watchdog_err, spurious_wb);
  endtask

  function automatic vec_t mk(bit v, bit [3:0] o1, bit i1, bit [3:0] o2, bit i2,
                              bit [3:0] d, bit id, bit [1:0] wbv, bit [7:0] wbd, bit fl,
                              bit rdy, bit [15:0] hold, bit bsy, bit [7:0] cnt, bit spur);
    vec_t r;
    r.s.valid = v; r.s.o1 = o1; r.s.is1 = i1; r.s.o2 = o2; r.s.is2 = i2;
    r.s.d = d; r.s.isd = id; r.s.wbv = wbv; r.s.wbd = wbd; r.s.fl = fl;
    r.rdy = rdy; r.hold = hold; r.busy = bsy; r.cnt = cnt; r.spur = spur;
    return r;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.valid = 0; s.o1 = 0; s.is1 = 0; s.o2 = 0; s.is2 = 0;
    s.d = 0; s.isd = 0; s.wbv = 0; s.wbd = 0; s.fl = 0;
    return s;
  endfunction

  function automatic bit [3:0] pick_held();
    int st = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++)
      if (m_hold[(st + i) % 16] && $urandom_range(0, 7) != 0) return 4'((st + i) % 16);
    return 4'(st);
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, " hold_Q"}, hold_Q, 16'h0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " stall_cycles"}, stall_cycles, 8'd0);
    chk({tag, " watchdog_err"}, watchdog_err, 1'b0);
    chk({tag, " spurious_wb"}, spurious_wb, 1'b0);
  endtask

  initial begin : global_timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t  tbl[$];
    stim_t s;
    bit    r;

    // Directed table (expected values worked out by hand).
    tbl.push_back(mk(1,0,0,0,0,3,1,2'b00,8'h00,0, 1,16'h0008,0,0,0)); // issue r3
    tbl.push_back(mk(1,3,1,0,0,0,0,2'b00,8'h00,0, 0,16'h0008,1,0,0)); // RAW -> STALL
    tbl.push_back(mk(1,3,1,0,0,0,0,2'b00,8'h00,0, 0,16'h0008,1,1,0));
    tbl.push_back(mk(1,3,1,0,0,0,0,2'b00,8'h00,0, 0,16'h0008,1,2,0));
    tbl.push_back(mk(1,3,1,0,0,0,0,2'b00,8'h00,0, 0,16'h0008,1,3,0));
    tbl.push_back(mk(1,3,1,0,0,0,0,2'b01,8'h03,0, 1,16'h0000,0,0,0)); // wb bypass
    tbl.push_back(mk(1,0,0,0,0,5,1,2'b00,8'h00,0, 1,16'h0020,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,5,1,2'b10,8'h50,0, 1,16'h0020,0,0,0)); // set beats clear
    tbl.push_back(mk(1,0,0,0,0,1,1,2'b01,8'h05,0, 1,16'h0002,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,2,1,2'b00,8'h00,0, 1,16'h0006,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,4,1,2'b00,8'h00,1, 0,16'h0006,1,0,0)); // flush blocks issue
    tbl.push_back(mk(1,0,0,0,0,4,1,2'b00,8'h00,0, 0,16'h0006,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b01,8'h01,0, 0,16'h0004,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b10,8'h20,0, 0,16'h0000,0,0,0)); // drain done
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b00,8'h00,0, 1,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b01,8'h09,0, 1,16'h0000,0,0,1)); // spurious
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b00,8'h00,0, 1,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b00,8'h00,1, 0,16'h0000,1,0,0)); // flush, empty
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b00,8'h00,0, 0,16'h0000,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,6,1,2'b00,8'h00,0, 1,16'h0040,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b11,8'h66,0, 1,16'h0000,0,0,0)); // dual wb same reg
    tbl.push_back(mk(1,0,0,0,0,10,1,2'b00,8'h00,0, 1,16'h0400,0,0,0));
    tbl.push_back(mk(1,10,0,10,0,11,1,2'b00,8'h00,0, 1,16'h0C00,0,0,0)); // unqualified idx
    tbl.push_back(mk(1,0,0,0,0,10,1,2'b00,8'h00,0, 0,16'h0C00,1,0,0)); // WAW
    tbl.push_back(mk(0,0,0,0,0,10,1,2'b00,8'h00,0, 0,16'h0C00,0,0,0)); // withdraw
    tbl.push_back(mk(0,0,0,0,0,0,0,2'b11,8'hBA,0, 1,16'h0000,0,0,0));

    // Reset state.
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    chk("reset issue_ready", issue_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i].s, $sformatf("tbl%0d", i), r);
      chk($sformatf("tbl%0d ready(tab)", i), r, tbl[i].rdy);
      chk($sformatf("tbl%0d hold(tab)", i), hold_Q, tbl[i].hold);
      chk($sformatf("tbl%0d busy(tab)", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d cnt(tab)", i), stall_cycles, tbl[i].cnt);
      chk($sformatf("tbl%0d spur(tab)", i), spurious_wb, tbl[i].spur);
    end

    // Watchdog: hold r7 and keep a dependent instruction waiting.
    s = idle(); s.valid = 1; s.d = 7; s.isd = 1;
    run_cycle(s, "wd_set", r);
    s = idle(); s.valid = 1; s.o2 = 7; s.is2 = 1;
    for (int i = 0; i < 255; i++) run_cycle(s, "wd_stall", r);
    chk("wd before limit", watchdog_err, 1'b0);
    chk("wd count at 254", stall_cycles, 8'd254);
    run_cycle(s, "wd_stall", r);
    chk("wd at limit", watchdog_err, 1'b1);
    chk("wd count 255", stall_cycles, 8'd255);
    run_cycle(s, "wd_sat", r);
    chk("wd count saturates", stall_cycles, 8'd255);
    s.wbv = 2'b01; s.wbd = 8'h07;
    run_cycle(s, "wd_clear", r);
    s = idle();
    repeat (3) run_cycle(s, "wd_idle", r);
    chk("wd sticky", watchdog_err, 1'b1);

    // Async reset while stalled.
    s = idle(); s.valid = 1; s.d = 8; s.isd = 1;
    run_cycle(s, "rst_hold", r);
    s = idle(); s.valid = 1; s.o1 = 8; s.is1 = 1;
    repeat (3) run_cycle(s, "rst_stall", r);
    chk("pre-rst busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    chk("midrst issue_ready", issue_ready, 1'b1);
    model_reset();
    drive(idle());
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.valid = ($urandom_range(0, 3) != 0);
      s.o1 = 4'($urandom_range(0, 15)); s.is1 = 1'($urandom_range(0, 1));
      s.o2 = 4'($urandom_range(0, 15)); s.is2 = 1'($urandom_range(0, 1));
      s.d  = 4'($urandom_range(0, 15)); s.isd = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          s.wbv[k] = 1'b1;
          s.wbd[k*4 +: 4] = pick_held();
        end
      end
      s.fl = ($urandom_range(0, 39) == 0);
      run_cycle(s, $sformatf("rnd%0d", n), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_hold_scoreboard
